// File: rtl/gestor_botones_pkg.sv
// Shared state encoding, default timing constants and width helpers
// for the button-change manager.
package gestor_botones_pkg;

    typedef enum logic [1:0] {
        REPOSO         = 2'd0,
        FILTRO         = 2'd1,
        ESPERA_RETARDO = 2'd2,
        REPETICION     = 2'd3
    } estado_t;

    localparam int N_CANALES_DEF   = 4;
    localparam int ANTIRREBOTE_DEF = 16;
    localparam int RETARDO_DEF     = 1000;
    localparam int REPETICION_DEF  = 250;

    // Counter width large enough to hold the largest of the three limits.
    function automatic int ancho_contador(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // Channel index width; a single channel still needs one bit.
    function automatic int ancho_indice(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/canal_boton.sv
// One button pair: debounce filter, initial pulse, hold delay and
// auto-repeat, producing registered one-cycle pulses.
//
// state          | meaning
// ---------------+-------------------------------------------------
// REPOSO         | no request; counter cleared
// FILTRO         | counting consecutive samples of the same request
// ESPERA_RETARDO | first pulse sent, waiting the hold delay
// REPETICION     | auto-repeat, one pulse per repeat period
module canal_boton
    import gestor_botones_pkg::*;
#(
    parameter int CICLOS_ANTIRREBOTE = ANTIRREBOTE_DEF,
    parameter int CICLOS_RETARDO     = RETARDO_DEF,
    parameter int CICLOS_REPETICION  = REPETICION_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic aumentar,
    input  logic disminuir,
    output logic pulso_aumentar,
    output logic pulso_disminuir
);

    localparam int W_CNT = ancho_contador(CICLOS_ANTIRREBOTE, CICLOS_RETARDO, CICLOS_REPETICION);
    localparam logic [W_CNT-1:0] LIM_ANTIRREBOTE = W_CNT'(CICLOS_ANTIRREBOTE);
    localparam logic [W_CNT-1:0] LIM_RETARDO     = W_CNT'(CICLOS_RETARDO);
    localparam logic [W_CNT-1:0] LIM_REPETICION  = W_CNT'(CICLOS_REPETICION);
    localparam logic [W_CNT-1:0] UNO             = W_CNT'(1);
    localparam logic [W_CNT-1:0] CNT_MAX         = '1;

    estado_t          estado, estado_sig;
    logic [W_CNT-1:0] cnt, cnt_sig;
    logic             dir, dir_sig;          // 0 = aumentar, 1 = disminuir
    logic             emitir;
    logic             solicitud, mismo;
    logic [W_CNT-1:0] cnt_inc;

    assign solicitud = aumentar ^ disminuir;
    assign mismo     = solicitud && (disminuir == dir);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + UNO;

    // Next-state, counter and pulse decision.
    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        dir_sig    = dir;
        emitir     = 1'b0;
        case (estado)
            REPOSO: begin
                cnt_sig = '0;
                if (solicitud) begin
                    estado_sig = FILTRO;
                    cnt_sig    = UNO;
                    dir_sig    = disminuir;
                end
            end
            FILTRO: begin
                if (!mismo) begin
                    estado_sig = REPOSO;
                    cnt_sig    = '0;
                end else if (cnt >= LIM_ANTIRREBOTE) begin
                    emitir     = 1'b1;
                    estado_sig = ESPERA_RETARDO;
                    cnt_sig    = UNO;
                end else begin
                    cnt_sig = cnt_inc;
                end
            end
            ESPERA_RETARDO: begin
                if (!mismo) begin
                    estado_sig = REPOSO;
                    cnt_sig    = '0;
                end else if (cnt >= LIM_RETARDO) begin
                    emitir     = 1'b1;
                    estado_sig = REPETICION;
                    cnt_sig    = UNO;
                end else begin
                    cnt_sig = cnt_inc;
                end
            end
            REPETICION: begin
                if (!mismo) begin
                    estado_sig = REPOSO;
                    cnt_sig    = '0;
                end else if (cnt >= LIM_REPETICION) begin
                    emitir  = 1'b1;
                    cnt_sig = UNO;
                end else begin
                    cnt_sig = cnt_inc;
                end
            end
            default: begin
                estado_sig = REPOSO;
                cnt_sig    = '0;
            end
        endcase
    end

    // State, counter, latched direction and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado          <= REPOSO;
            cnt             <= '0;
            dir             <= 1'b0;
            pulso_aumentar  <= 1'b0;
            pulso_disminuir <= 1'b0;
        end else begin
            estado          <= estado_sig;
            cnt             <= cnt_sig;
            dir             <= dir_sig;
            pulso_aumentar  <= emitir & ~dir;
            pulso_disminuir <= emitir & dir;
        end
    end

endmodule

// File: rtl/gestor_cambio_botones.sv
// Button-change manager: N independent channels, a sticky change flag
// toward the FSM and the index of the last channel that produced an event.
module gestor_cambio_botones
    import gestor_botones_pkg::*;
#(
    parameter int N_CANALES          = N_CANALES_DEF,
    parameter int CICLOS_ANTIRREBOTE = ANTIRREBOTE_DEF,
    parameter int CICLOS_RETARDO     = RETARDO_DEF,
    parameter int CICLOS_REPETICION  = REPETICION_DEF,
    localparam int W_IDX = ancho_indice(N_CANALES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reset_cambio,
    input  logic [N_CANALES-1:0] aumentar,
    input  logic [N_CANALES-1:0] disminuir,
    output logic [N_CANALES-1:0] pulso_aumentar,
    output logic [N_CANALES-1:0] pulso_disminuir,
    output logic                 cambio,
    output logic [W_IDX-1:0]     canal_ultimo
);

    // Two-stage release synchroniser: assertion is immediate, release
    // reaches the channels two edges later, so the first sample after
    // reset happens on the third rising edge after rst goes high.
    logic [1:0] rst_sinc;
    logic       rst_int;
    logic       hay_pulso;
    logic [W_IDX-1:0] indice;

    // Reset synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sinc <= 2'b00;
        else      rst_sinc <= {rst_sinc[0], 1'b1};
    end

    assign rst_int = rst_sinc[1];

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        canal_boton #(
            .CICLOS_ANTIRREBOTE (CICLOS_ANTIRREBOTE),
            .CICLOS_RETARDO     (CICLOS_RETARDO),
            .CICLOS_REPETICION  (CICLOS_REPETICION)
        ) u_canal (
            .clk             (clk),
            .rst             (rst_int),
            .aumentar        (aumentar[i]),
            .disminuir       (disminuir[i]),
            .pulso_aumentar  (pulso_aumentar[i]),
            .pulso_disminuir (pulso_disminuir[i])
        );
    end

    // Priority encoder: lowest-indexed channel currently pulsing.
    always_comb begin
        hay_pulso = |(pulso_aumentar | pulso_disminuir);
        indice    = '0;
        for (int i = N_CANALES - 1; i >= 0; i--) begin
            if (pulso_aumentar[i] | pulso_disminuir[i]) indice = W_IDX'(i);
        end
    end

    // Sticky change flag; a pulse takes priority over the clear request.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            cambio       <= 1'b0;
            canal_ultimo <= '0;
        end else if (hay_pulso) begin
            cambio       <= 1'b1;
            canal_ultimo <= indice;
        end else if (reset_cambio) begin
            cambio <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gestor_cambio_botones.sv
// Directed bench: a 4-channel instance (filter 4, delay 10, repeat 5)
// and a 1-channel instance (filter 1) sharing clock and reset.
module tb_gestor_cambio_botones;

    logic       clk = 1'b0;
    logic       rst;
    logic       reset_cambio;
    logic [3:0] aumentar, disminuir;
    logic [3:0] pulso_aumentar, pulso_disminuir;
    logic       cambio;
    logic [1:0] canal_ultimo;

    logic       reset_cambio_u;
    logic [0:0] aumentar_u, disminuir_u;
    logic [0:0] pulso_aumentar_u, pulso_disminuir_u;
    logic       cambio_u;
    logic [0:0] canal_ultimo_u;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gestor_cambio_botones #(
        .N_CANALES          (4),
        .CICLOS_ANTIRREBOTE (4),
        .CICLOS_RETARDO     (10),
        .CICLOS_REPETICION  (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reset_cambio    (reset_cambio),
        .aumentar        (aumentar),
        .disminuir       (disminuir),
        .pulso_aumentar  (pulso_aumentar),
        .pulso_disminuir (pulso_disminuir),
        .cambio          (cambio),
        .canal_ultimo    (canal_ultimo)
    );

    gestor_cambio_botones #(
        .N_CANALES          (1),
        .CICLOS_ANTIRREBOTE (1),
        .CICLOS_RETARDO     (10),
        .CICLOS_REPETICION  (5)
    ) dut_u (
        .clk             (clk),
        .rst             (rst),
        .reset_cambio    (reset_cambio_u),
        .aumentar        (aumentar_u),
        .disminuir       (disminuir_u),
        .pulso_aumentar  (pulso_aumentar_u),
        .pulso_disminuir (pulso_disminuir_u),
        .cambio          (cambio_u),
        .canal_ultimo    (canal_ultimo_u)
    );

    // After this returns, outputs show the cycle that began at the last edge;
    // inputs driven now are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b0;
        reset_cambio   = 1'b0;
        aumentar       = 4'b0000;
        disminuir      = 4'b0000;
        reset_cambio_u = 1'b0;
        aumentar_u     = 1'b0;
        disminuir_u    = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_pa", pulso_aumentar, 4'b0000);
        chk("rst_pd", pulso_disminuir, 4'b0000);
        chk("rst_cambio", cambio, 1'b0);
        chk("rst_canal", canal_ultimo, 2'd0);
        chk("rst_cambio_u", cambio_u, 1'b0);
        #2 rst = 1'b1;
        repeat (5) step();

        // Held press on channel 2: single pulse in cycle 4, flag in cycle 5
        aumentar = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("t1_pa c%0d", c), pulso_aumentar, (c == 4) ? 4'b0100 : 4'b0000);
            chk($sformatf("t1_pd c%0d", c), pulso_disminuir, 4'b0000);
            chk($sformatf("t1_cambio c%0d", c), cambio, (c >= 5));
            if (c >= 5) chk($sformatf("t1_canal c%0d", c), canal_ultimo, 2'd2);
        end
        aumentar = 4'b0000;
        step();
        step();
        reset_cambio = 1'b1;
        step();
        reset_cambio = 1'b0;
        chk("t1_clear_cambio", cambio, 1'b0);
        chk("t1_canal_hold", canal_ultimo, 2'd2);

        // Long hold on disminuir[0]: 4, 14, then every 5 until release
        disminuir = 4'b0001;
        for (int c = 0; c < 50; c++) begin
            logic esp;
            step();
            esp = (c == 4) || (c == 14) || (c == 19) || (c == 24) ||
                  (c == 29) || (c == 34) || (c == 39);
            chk($sformatf("t2_pd c%0d", c), pulso_disminuir, esp ? 4'b0001 : 4'b0000);
            chk($sformatf("t2_pa c%0d", c), pulso_aumentar, 4'b0000);
            if (c == 5) begin
                chk("t2_cambio", cambio, 1'b1);
                chk("t2_canal", canal_ultimo, 2'd0);
            end
            if (c == 39) disminuir = 4'b0000;
        end
        reset_cambio = 1'b1;
        step();
        reset_cambio = 1'b0;
        chk("t2_clear_cambio", cambio, 1'b0);

        // Glitched press on channel 1 (3 high, 1 low, 3 high): nothing
        for (int c = 0; c < 14; c++) begin
            aumentar = ((c < 3) || (c >= 4 && c < 7)) ? 4'b0010 : 4'b0000;
            step();
            chk($sformatf("t3_pa c%0d", c), pulso_aumentar, 4'b0000);
            chk($sformatf("t3_cambio c%0d", c), cambio, 1'b0);
        end
        // Both buttons of channel 3 held: no request
        aumentar  = 4'b1000;
        disminuir = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("t3b_pa c%0d", c), pulso_aumentar, 4'b0000);
            chk($sformatf("t3b_pd c%0d", c), pulso_disminuir, 4'b0000);
            chk($sformatf("t3b_cambio c%0d", c), cambio, 1'b0);
        end
        aumentar  = 4'b0000;
        disminuir = 4'b0000;
        step();

        // Channels 1 and 3 pulse together with a clear request in that cycle
        aumentar  = 4'b0010;
        disminuir = 4'b1000;
        for (int c = 0; c < 9; c++) begin
            step();
            chk($sformatf("t4_pa c%0d", c), pulso_aumentar, (c == 4) ? 4'b0010 : 4'b0000);
            chk($sformatf("t4_pd c%0d", c), pulso_disminuir, (c == 4) ? 4'b1000 : 4'b0000);
            chk($sformatf("t4_cambio c%0d", c), cambio, (c >= 5));
            if (c == 4) reset_cambio = 1'b1;
            if (c == 5) begin
                chk("t4_canal", canal_ultimo, 2'd1);
                reset_cambio = 1'b0;
                aumentar     = 4'b0000;
                disminuir    = 4'b0000;
            end
        end
        reset_cambio = 1'b1;
        step();
        reset_cambio = 1'b0;
        chk("t4_clear_cambio", cambio, 1'b0);
        chk("t4_canal_hold", canal_ultimo, 2'd1);
        step();
        chk("t4_cambio_stays0", cambio, 1'b0);

        // Async reset during auto-repeat, button kept held
        aumentar = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("t5_pa c%0d", c), pulso_aumentar,
                ((c == 4) || (c == 14) || (c == 19)) ? 4'b0100 : 4'b0000);
        end
        chk("t5_pre_cambio", cambio, 1'b1);
        chk("t5_pre_canal", canal_ultimo, 2'd2);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_pa", pulso_aumentar, 4'b0000);
        chk("t5_async_pd", pulso_disminuir, 4'b0000);
        chk("t5_async_cambio", cambio, 1'b0);
        chk("t5_async_canal", canal_ultimo, 2'd0);
        step();
        chk("t5_inreset_pa", pulso_aumentar, 4'b0000);
        step();
        #3 rst = 1'b1;
        // Release synchroniser: first channel sample on the 3rd edge after
        // release (k=3), pulse 4 edges later (k=7).
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("t5_post_pa k%0d", k), pulso_aumentar, (k == 7) ? 4'b0100 : 4'b0000);
            chk($sformatf("t5_post_cambio k%0d", k), cambio, (k >= 8));
        end
        chk("t5_post_canal", canal_ultimo, 2'd2);
        aumentar = 4'b0000;

        // Single channel, filter of one sample
        step();
        chk("t6_cambio_init", cambio_u, 1'b0);
        aumentar_u = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            chk($sformatf("t6_pa c%0d", c), pulso_aumentar_u, (c == 1));
            chk($sformatf("t6_pd c%0d", c), pulso_disminuir_u, 1'b0);
            chk($sformatf("t6_cambio c%0d", c), cambio_u, (c >= 2));
            if (c >= 2) chk($sformatf("t6_canal c%0d", c), canal_ultimo_u, 1'b0);
        end
        aumentar_u = 1'b0;
        step();
        disminuir_u = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t6b_pd c%0d", c), pulso_disminuir_u, (c == 1));
            chk($sformatf("t6b_pa c%0d", c), pulso_aumentar_u, 1'b0);
        end
        chk("t6b_canal", canal_ultimo_u, 1'b0);
        disminuir_u = 1'b0;
        step();
        reset_cambio_u = 1'b1;
        step();
        reset_cambio_u = 1'b0;
        chk("t6_clear_cambio", cambio_u, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gestor_cambio_botones.md
GESTOR_CAMBIO_BOTONES -- requirements
Module: gestor_cambio_botones

Interface
REQ-001 SHALL have parameter N_CANALES, default 4, meaning the number of independent aumentar/disminuir button pairs (1..16).
REQ-002 SHALL have parameter CICLOS_ANTIRREBOTE, default 16, meaning consecutive stable high samples required to accept a press (>=1).
REQ-003 SHALL have parameter CICLOS_RETARDO, default 1000, meaning hold cycles after the first pulse before auto-repeat starts (>=1).
REQ-004 SHALL have parameter CICLOS_REPETICION, default 250, meaning the period between auto-repeat pulses (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port reset_cambio, input, 1, clear request for the cambio flag from the FSM.
REQ-008 SHALL have port aumentar, input, N_CANALES, per-channel increment buttons, already metastability-filtered.
REQ-009 SHALL have port disminuir, input, N_CANALES, per-channel decrement buttons, already metastability-filtered.
REQ-010 SHALL have port pulso_aumentar, output, N_CANALES, one-cycle increment events.
REQ-011 SHALL have port pulso_disminuir, output, N_CANALES, one-cycle decrement events.
REQ-012 SHALL have port cambio, output, 1, sticky "write requested" flag toward the FSM.
REQ-013 SHALL have port canal_ultimo, output, max(1,clog2(N_CANALES)), index of the channel that last produced an event.

Function
REQ-014 Each channel SHALL run an independent FSM with states REPOSO, FILTRO, ESPERA_RETARDO and REPETICION.
REQ-015 A channel's request SHALL be "exactly one of aumentar[i]/disminuir[i] high"; both high or both low SHALL count as no request.
REQ-016 REPOSO->FILTRO SHALL occur on a request; the filter counter SHALL load 1 and the requested direction SHALL be latched.
REQ-017 In FILTRO, the counter SHALL increment on each further sample with the same request; on reaching CICLOS_ANTIRREBOTE the FSM SHALL emit one pulse in the latched direction in the next cycle and enter ESPERA_RETARDO.
REQ-018 Any loss or direction change of the request in FILTRO, ESPERA_RETARDO or REPETICION SHALL return the channel to REPOSO in the next cycle with no pulse.
REQ-019 In ESPERA_RETARDO, after CICLOS_RETARDO held cycles following the first pulse, the FSM SHALL emit one pulse and enter REPETICION.
REQ-020 In REPETICION, the FSM SHALL emit one pulse every CICLOS_REPETICION cycles while the request holds.
REQ-021 Pulses SHALL be exactly one cycle wide; pulso_aumentar[i] and pulso_disminuir[i] SHALL never be high together.
REQ-022 Counters SHALL saturate and never wrap; widths SHALL be clog2(max parameter + 1).
REQ-023 cambio SHALL set in the cycle after any pulse is emitted on any channel.
REQ-024 cambio SHALL clear in the cycle after reset_cambio is high with no pulse; a simultaneous pulse SHALL win and cambio SHALL stay 1.
REQ-025 canal_ultimo SHALL update in the same cycle cambio sets, to the lowest-indexed channel pulsing; otherwise it SHALL hold its value.

Reset
REQ-026 rst low SHALL asynchronously force all FSMs to REPOSO, all counters to 0, and pulso_aumentar, pulso_disminuir, cambio and canal_ultimo to 0.
REQ-027 Reset deassertion SHALL be synchronised to clk; no pulse SHALL be emitted in the first cycle after release, even if a button is held.
REQ-028 A button held across reset SHALL restart the full CICLOS_ANTIRREBOTE filter.

Structure
REQ-029 The FSM state encoding and default timing constants SHALL live in the shared package gestor_botones_pkg.
REQ-030 The per-channel FSM and counters SHALL be the sub-module canal_boton, generated N_CANALES times; the top level SHALL hold only cambio/canal_ultimo logic and the priority encoder.

Verification
Use ANTIRREBOTE=4, RETARDO=10, REPETICION=5, N_CANALES=4 unless stated.
REQ-031 Bench SHALL hold aumentar[2] high from cycle 0 -> pulso_aumentar[2] in cycle 4 only; cambio=1 and canal_ultimo=2 in cycle 5.
REQ-032 Bench SHALL hold disminuir[0] for 40 cycles -> pulses in cycles 4, 14, 19, 24, 29, 34, 39 -> none after release.
REQ-033 Bench SHALL assert aumentar[1] for 3 cycles and then a glitch -> no pulse and cambio stays 0; bench SHALL hold both aumentar[3] and disminuir[3] for 20 cycles -> no pulse.
REQ-034 Bench SHALL make channels 1 and 3 pulse in the same cycle -> canal_ultimo=1; bench SHALL assert reset_cambio in that same cycle -> cambio remains 1; bench SHALL assert reset_cambio alone later -> cambio=0 next cycle.
REQ-035 Bench SHALL drive rst low mid-REPETICION asynchronously between clock edges -> all outputs 0 immediately; with the button still held after release -> next pulse exactly 4 cycles after the first post-reset sample.
REQ-036 Bench SHALL run with N_CANALES=1 and ANTIRREBOTE=1 -> pulse in the cycle after the first high sample; canal_ultimo is 1 bit and stays 0.
